rc4_key_scheduler: RTL

Top-level sequencer for the RC4 brute-force key search. It runs the three RC4 phase engines in order for each candidate key: S-array init, key scheduling (KSA), and decrypt. It owns the single S-RAM port and muxes it to whichever phase is active. It also checks every decrypted byte and either stops on a key that yields a plausible message or advances to the next key.

---
 rtl/rc4_pkg.sv | 37 +++
 rtl/rc4_key_scheduler_if.sv | 50 +++++
 rtl/rc4_byte_checker.sv | 30 +++
 rtl/rc4_key_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared states, constants and types for the RC4 key scheduler
package rc4_pkg;

  localparam int              KEY_W    = 24;
  localparam logic [KEY_W-1:0] KEY_MAX = 24'h3F_FFFF;
  localparam int              MSG_LEN  = 32;
  localparam int              CNT_W    = 8;

  localparam logic [7:0] ASCII_LO = 8'h61;
  localparam logic [7:0] ASCII_HI = 8'h7A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_START,
    ST_INIT_WAIT,
    ST_KSA_START,
    ST_KSA_WAIT,
    ST_DEC_START,
    ST_DEC_WAIT,
    ST_CHECK,
    ST_NEXT_KEY,
    ST_FOUND,
    ST_EXHAUSTED
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       wen;
  } sram_port_t;

  function automatic logic is_text_byte(input logic [7:0] b);
    return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SP);
  endfunction

endpackage

// File: rtl/rc4_key_scheduler_if.sv
// rtl/rc4_key_scheduler_if.sv - engine handshakes, S-RAM requesters and decrypt monitor bus
interface rc4_key_scheduler_if;
  import rc4_pkg::*;

  logic             init_start;
  logic             ksa_start;
  logic             dec_start;
  logic             init_finish;
  logic             ksa_finish;
  logic             dec_finish;
  logic [7:0]       init_addr;
  logic [7:0]       ksa_addr;
  logic [7:0]       dec_addr;
  logic [7:0]       init_data;
  logic [7:0]       ksa_data;
  logic [7:0]       dec_data;
  logic             init_wen;
  logic             ksa_wen;
  logic             dec_wen;
  logic [7:0]       s_addr;
  logic [7:0]       s_data;
  logic             s_wen;
  logic             dec_out_wen;
  logic [7:0]       dec_out_data;
  logic             dec_abort;
  logic [KEY_W-1:0] secret_key;

  modport master (
    output init_start, ksa_start, dec_start,
    input  init_finish, ksa_finish, dec_finish,
    input  init_addr, ksa_addr, dec_addr,
    input  init_data, ksa_data, dec_data,
    input  init_wen, ksa_wen, dec_wen,
    output s_addr, s_data, s_wen,
    input  dec_out_wen, dec_out_data,
    output dec_abort, secret_key
  );

  modport slave (
    input  init_start, ksa_start, dec_start,
    output init_finish, ksa_finish, dec_finish,
    output init_addr, ksa_addr, dec_addr,
    output init_data, ksa_data, dec_data,
    output init_wen, ksa_wen, dec_wen,
    input  s_addr, s_data, s_wen,
    output dec_out_wen, dec_out_data,
    input  dec_abort, secret_key
  );

endinterface

// File: rtl/rc4_byte_checker.sv
// rtl/rc4_byte_checker.sv - counts decrypted bytes and flags any byte outside lowercase/space
module rc4_byte_checker
  import rc4_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             wen,
  input  logic [7:0]       data,
  output logic [CNT_W-1:0] count,
  output logic             bad
);

  // count saturates so an over-long message can never alias back to MSG_LEN
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
      bad   <= 1'b0;
    end else if (enable && wen) begin
      if (count != {CNT_W{1'b1}}) begin
        count <= count + 1'b1;
      end
      if (!is_text_byte(data)) begin
        bad <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rc4_key_scheduler.sv
// rtl/rc4_key_scheduler.sv - RC4 key-search sequencer; RC4_EARLY_ABORT_EN enables early decrypt abort
module rc4_key_scheduler
  import rc4_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [KEY_W-1:0] key_base,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  rc4_key_scheduler_if.master eng
);

  state_t           state;
  logic             phase_done;
  logic             init_start_q;
  logic             ksa_start_q;
  logic             dec_start_q;
  logic [KEY_W-1:0] key_q;
  logic [CNT_W-1:0] byte_count;
  logic             msg_bad;
  logic             msg_ok;
  sram_port_t       s_port;

  rc4_byte_checker u_checker (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ST_INIT_START),
    .enable (state == ST_DEC_WAIT),
    .wen    (eng.dec_out_wen),
    .data   (eng.dec_out_data),
    .count  (byte_count),
    .bad    (msg_bad)
  );

  assign msg_ok = !msg_bad && (byte_count == CNT_W'(MSG_LEN));

`ifdef RC4_EARLY_ABORT_EN
  logic abort_q;
  logic abort_now;
  assign abort_now     = eng.dec_out_wen && !is_text_byte(eng.dec_out_data);
  assign eng.dec_abort = abort_q;
`else
  assign eng.dec_abort = 1'b0;
`endif

  assign eng.init_start = init_start_q;
  assign eng.ksa_start  = ksa_start_q;
  assign eng.dec_start  = dec_start_q;
  assign eng.secret_key = key_q;

  always_comb begin
    s_port = '0;
    case (state)
      ST_INIT_START, ST_INIT_WAIT:
        s_port = '{addr: eng.init_addr, data: eng.init_data, wen: eng.init_wen};
      ST_KSA_START, ST_KSA_WAIT:
        s_port = '{addr: eng.ksa_addr, data: eng.ksa_data, wen: eng.ksa_wen};
      ST_DEC_START, ST_DEC_WAIT:
        s_port = '{addr: eng.dec_addr, data: eng.dec_data, wen: eng.dec_wen};
      default:
        s_port = '0;
    endcase
  end

  assign eng.s_addr = s_port.addr;
  assign eng.s_data = s_port.data;
  assign eng.s_wen  = s_port.wen;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      phase_done   <= 1'b0;
      init_start_q <= 1'b0;
      ksa_start_q  <= 1'b0;
      dec_start_q  <= 1'b0;
      key_q        <= '0;
      busy         <= 1'b0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
`ifdef RC4_EARLY_ABORT_EN
      abort_q      <= 1'b0;
`endif
    end else begin
      init_start_q <= 1'b0;
      ksa_start_q  <= 1'b0;
      dec_start_q  <= 1'b0;
`ifdef RC4_EARLY_ABORT_EN
      abort_q      <= 1'b0;
`endif
      case (state)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
          if (go) begin
            state        <= ST_INIT_START;
            init_start_q <= 1'b1;
            key_q        <= key_base;
            busy         <= 1'b1;
            found        <= 1'b0;
            exhausted    <= 1'b0;
          end
        end
        ST_INIT_START: begin
          state      <= ST_INIT_WAIT;
          phase_done <= 1'b0;
        end
        // the finishing engine keeps the S-RAM one extra cycle so a write
        // issued alongside its finish lands before ownership moves on
        ST_INIT_WAIT: begin
          if (phase_done) begin
            state       <= ST_KSA_START;
            ksa_start_q <= 1'b1;
            phase_done  <= 1'b0;
          end else if (eng.init_finish) begin
            phase_done <= 1'b1;
          end
        end
        ST_KSA_START: begin
          state <= ST_KSA_WAIT;
        end
        ST_KSA_WAIT: begin
          if (phase_done) begin
            state       <= ST_DEC_START;
            dec_start_q <= 1'b1;
            phase_done  <= 1'b0;
          end else if (eng.ksa_finish) begin
            phase_done <= 1'b1;
          end
        end
        ST_DEC_START: begin
          state <= ST_DEC_WAIT;
        end
        ST_DEC_WAIT: begin
`ifdef RC4_EARLY_ABORT_EN
          if (abort_now) begin
            state   <= ST_NEXT_KEY;
            abort_q <= 1'b1;
          end else
`endif
          if (eng.dec_finish) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (msg_ok) begin
            state <= ST_FOUND;
            found <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= ST_NEXT_KEY;
          end
        end
        // >= also stops a search whose base was already past the last key
        ST_NEXT_KEY: begin
          if (key_q >= KEY_MAX) begin
            state     <= ST_EXHAUSTED;
            exhausted <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state        <= ST_INIT_START;
            init_start_q <= 1'b1;
            key_q        <= key_q + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
